// File: rtl/gen_velocidades.sv
// gen_velocidades: slow/medium/fast one-cycle tick trains plus a saturating race-progress counter,
// gated by an IDLE/RUN/CHOQUE FSM. Optional macro VEL_PENALIZACION_EN: a crash subtracts PENALTY (floored at 0).
module gen_velocidades #(
   parameter logic [23:0] DIV0      = 24'd6_000_000,
   parameter logic [23:0] DIV1      = 24'd4_000_000,
   parameter logic [23:0] DIV2      = 24'd2_000_000,
   parameter logic [23:0] PROG_DIV  = 24'd12_500_000,
   parameter logic [8:0]  CONT_MAX  = 9'd400,
   parameter logic [23:0] CRASH_CYC = 24'd25_000_000,
   parameter logic [8:0]  PENALTY   = 9'd50
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       choque,
   output logic [8:0] contador,
   output logic [2:0] v,
   output logic       corriendo
);

`ifdef VEL_PENALIZACION_EN
   localparam logic PEN_EN = 1'b1;
`else
   localparam logic PEN_EN = 1'b0;
`endif
   // With the feature off the effective penalty is zero, so a crash leaves contador untouched.
   localparam logic [8:0]  PEN_EFF = PEN_EN ? PENALTY : 9'd0;
   localparam logic [71:0] DIV_VEC = {DIV2, DIV1, DIV0};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_CHOQUE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        w_enter_run;
   logic        w_enter_crash;
   logic        w_advance;
   logic        w_crash_done;

   logic [23:0] r_div [3];
   logic [2:0]  w_div_tc;
   logic [2:0]  r_v;
   logic [23:0] r_pdiv;
   logic        w_pdiv_tc;
   logic [8:0]  r_cont;
   logic [8:0]  w_cont_pen;
   logic [23:0] r_tmr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   assign w_crash_done = (r_tmr == CRASH_CYC - 24'd1);

   always_comb begin
      w_state_nxt   = r_state;
      w_enter_run   = 1'b0;
      w_enter_crash = 1'b0;
      w_advance     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_RUN;
               w_enter_run = 1'b1;
            end
         end
         ST_RUN: begin
            // A crash beats any terminal count on the same edge: nothing advances.
            if (choque) begin
               w_state_nxt   = ST_CHOQUE;
               w_enter_crash = 1'b1;
            end else begin
               w_advance = 1'b1;
            end
         end
         ST_CHOQUE: begin
            if (w_crash_done) begin
               w_state_nxt = ST_RUN;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      w_div_tc = '0;
      for (int unsigned i = 0; i < 3; i++) begin
         w_div_tc[i] = (r_div[i] == DIV_VEC[i*24 +: 24] - 24'd1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 3; i++) begin
            r_div[i] <= '0;
         end
         r_v <= '0;
      end else begin
         r_v <= '0;
         if (w_enter_run) begin
            for (int unsigned i = 0; i < 3; i++) begin
               r_div[i] <= '0;
            end
         end else if (w_advance) begin
            for (int unsigned i = 0; i < 3; i++) begin
               if (w_div_tc[i]) begin
                  r_div[i] <= '0;
                  r_v[i]   <= 1'b1;
               end else begin
                  r_div[i] <= r_div[i] + 24'd1;
               end
            end
         end
      end
   end

   assign w_pdiv_tc  = (r_pdiv == PROG_DIV - 24'd1);
   assign w_cont_pen = (r_cont > PEN_EFF) ? (r_cont - PEN_EFF) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pdiv <= '0;
         r_cont <= '0;
      end else if (w_enter_run) begin
         r_pdiv <= '0;
         r_cont <= '0;
      end else if (w_enter_crash) begin
         r_cont <= w_cont_pen;
      end else if (w_advance) begin
         if (w_pdiv_tc) begin
            r_pdiv <= '0;
            if (r_cont < CONT_MAX) begin
               r_cont <= r_cont + 9'd1;
            end
         end else begin
            r_pdiv <= r_pdiv + 24'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tmr <= '0;
      end else if (w_enter_run || w_enter_crash) begin
         r_tmr <= '0;
      end else if (r_state == ST_CHOQUE) begin
         if (w_crash_done) begin
            r_tmr <= '0;
         end else begin
            r_tmr <= r_tmr + 24'd1;
         end
      end
   end

   assign contador  = r_cont;
   assign v         = r_v;
   assign corriendo = (r_state == ST_RUN);

endmodule

// File: doc/gen_velocidades.md
# gen_velocidades

Upstream stage of the speed selector in the Fury on Wheels game. It generates three one-cycle speed tick trains (slow, medium, fast) and a 9-bit race-progress counter. The downstream selector compares that counter against its thresholds to pick which tick drives vehicle motion. A small FSM (idle / running / crashed) gates the ticks and the counter, so the race starts on command and freezes briefly after a collision.

## Interface
- `DIV0`, default 24'd6_000_000: slow tick period in clk cycles; must be ≥2.
- `DIV1`, default 24'd4_000_000: medium tick period; ≥2.
- `DIV2`, default 24'd2_000_000: fast tick period; ≥2.
- `PROG_DIV`, default 24'd12_500_000: clk cycles per progress increment; ≥2.
- `CONT_MAX`, default 9'd400: saturation value of `contador`; ≤511.
- `CRASH_CYC`, default 24'd25_000_000: freeze duration after a crash, in cycles; ≥1.
- `PENALTY`, default 9'd50: progress lost per crash (only with the macro).
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: level, sampled each clk; begins a race from IDLE.
- `choque` input 1: level, sampled each clk; collision indication.
- `contador` output 9: race progress, 0..CONT_MAX, registered.
- `v` output 3: v[0] slow, v[1] medium, v[2] fast tick; one-cycle pulses, registered.
- `corriendo` output 1: high while the state is RUN.

## Operation
- States:
  - IDLE: reset state. `v`=0. `contador` is held.
  - RUN
  - CHOQUE
- IDLE→RUN when `start`=1. On that edge:
  - `contador`←0.
  - All dividers and the crash timer are cleared.
- RUN→CHOQUE when `choque`=1. The crash timer is cleared.
- CHOQUE→RUN when the crash timer reaches CRASH_CYC-1. Dividers resume from their held values; `contador` is kept.
- Ignored inputs:
  - `start` in RUN or CHOQUE.
  - `choque` in IDLE or CHOQUE.
- No path returns to IDLE except reset.
- Tick dividers: three independent 24-bit counters `div_i`, one per tick.
  - In RUN, each increments every cycle.
  - When `div_i`==DIVi-1, `div_i`←0 and `v[i]`←1 for exactly one cycle; otherwise `v[i]`←0.
  - In IDLE and CHOQUE, dividers hold and `v`←0.
- Progress: a 24-bit divider `pdiv` uses the same rule with PROG_DIV.
  - On its terminal count, `contador`←`contador`+1, saturating at CONT_MAX.
  - At CONT_MAX, `pdiv` keeps running but `contador` does not change.
- Simultaneous events: `choque` in the same cycle as a progress terminal count or a tick terminal count means the CHOQUE transition wins.
  - No increment occurs and no tick is emitted.
  - Dividers hold their pre-edge values.
- All arithmetic is unsigned. 24-bit counters are compared with `==`, never `>=`.

## Timing
- Reset (async assert, sync release) forces:
  - state=IDLE, `contador`=0, `v`=3'b000, `corriendo`=0.
  - All internal counters to 0.
- Reset asserted mid-race aborts immediately. No tick or increment occurs after assertion.
- `corriendo` rises on the same edge that enters RUN (1-cycle latency from `start`).
- With the RUN entry edge as E0, the first `v[i]` pulse is high for the cycle after edge E_DIVi. Subsequent pulses repeat every DIVi RUN cycles.
- The first `contador` increment is visible after edge E_PROG_DIV.
- CHOQUE lasts exactly CRASH_CYC cycles; `corriendo` is low throughout.
- Outputs are free of combinational paths from inputs.

## Configuration
- `VEL_PENALIZACION_EN` defined: on the RUN→CHOQUE edge, `contador`←`contador`-PENALTY, floored at 0.
- `VEL_PENALIZACION_EN` undefined: `contador` is unchanged by a crash, and the PENALTY parameter is unused.

## Test plan
All scenarios use DIV0=8, DIV1=4, DIV2=2, PROG_DIV=10, CONT_MAX=5, CRASH_CYC=6, PENALTY=3.
- Reset, then hold `start`=0 for 50 cycles → `v`=0, `contador`=0, `corriendo`=0 throughout.
- Pulse `start` 1 cycle, then run 40 cycles → `corriendo`=1.
  - v[2] has 20 pulses, v[1] 10, v[0] 5, all one cycle wide.
  - `contador` steps 0→4 at cycles 10, 20, 30, 40.
- Continue to 80 cycles → `contador` saturates at 5 and stays 5; ticks continue unchanged.
- At `contador`=4, assert `choque` 1 cycle coinciding with a `pdiv` terminal count.
  - No increment occurs and `v`=0 for 6 cycles.
  - RUN resumes with `contador`=4 without the macro, or 1 with the macro.
  - The next tick phases continue from the held divider values.
- Assert `rst_n`=0 mid-pulse of v[2] during RUN → `v`, `contador` and `corriendo` go to 0 immediately.
  - After release, state is IDLE until the next `start`.
- Apply `start` and `choque` in RUN and in CHOQUE at various cycles → no restart or extension of CHOQUE; only RUN→CHOQUE reacts to `choque`.
